// File: rtl/axis_uart_fifo_core.sv
// Full-duplex UART with AXI-Stream TX/RX FIFOs, runtime divider/parity/stop config,
// internal loopback and per-word error tags. FSMs: IDLE|START|DATA|PARITY|STOP (+RX WAIT_HIGH after a framing error).

module axis_uart_fifo_sync #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] wdata,
   input  logic         rd,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp, rp;
   logic         rd_ok, wr_ok;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd_ok = rd && !empty;
   // a write into a full FIFO is fine when the head leaves in the same cycle
   assign wr_ok = wr && (!full || rd_ok);
   assign rdata = mem[rp[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_ok) wp <= wp + 1'b1;
         if (rd_ok) rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp[AW-1:0]] <= wdata;
   end
endmodule

module axis_uart_fifo_core #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DIV_WIDTH-1:0] clk_divider_i,
   input  logic                 parity_en_i,
   input  logic                 parity_odd_i,
   input  logic                 two_stop_i,
   input  logic                 loopback_i,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic [1:0]           m_axis_tuser,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 uart_rx_i,
   output logic                 uart_tx_o,
   output logic                 tx_busy_o,
   output logic                 rx_overrun_o,
   input  logic                 rx_overrun_clr_i
);
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
   localparam logic [3:0]           LAST_BIT = 4'(DATA_BITS - 1);

   logic [DIV_WIDTH-1:0] div_eff;
   logic                 run;
   assign div_eff = (clk_divider_i < DIV_MIN) ? DIV_MIN : clk_divider_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) run <= 1'b0;
      else       run <= 1'b1;
   end

   logic                 tx_full, tx_empty, tx_pop, tx_wr;
   logic [DATA_BITS-1:0] tx_rdata;
   tx_state_t            tx_state, tx_nx;
   logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
   logic [3:0]           tx_bitn;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par, tx_par_en, tx_two, tx_tick, tx_last, tx_ser;

   assign tx_pop        = (tx_state == TX_IDLE) && !tx_empty;
   assign s_axis_tready = run && (!tx_full || tx_pop);
   assign tx_wr         = s_axis_tvalid && s_axis_tready;
   assign tx_tick       = (tx_cnt == '0);
   assign tx_last       = (tx_bitn == LAST_BIT);
   assign tx_busy_o     = !tx_empty || (tx_state != TX_IDLE);
   assign uart_tx_o     = loopback_i ? 1'b1 : tx_ser;

   axis_uart_fifo_sync #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk_i), .rst(rst_i), .wr(tx_wr), .wdata(s_axis_tdata), .rd(tx_pop),
      .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
   );

   always_comb begin
      tx_nx  = tx_state;
      tx_ser = 1'b1;
      case (tx_state)
         TX_IDLE:   if (!tx_empty) tx_nx = TX_START;
         TX_START: begin
            tx_ser = 1'b0;
            if (tx_tick) tx_nx = TX_DATA;
         end
         TX_DATA: begin
            tx_ser = tx_sh[0];
            if (tx_tick && tx_last) tx_nx = tx_par_en ? TX_PARITY : TX_STOP;
         end
         TX_PARITY: begin
            tx_ser = tx_par;
            if (tx_tick) tx_nx = TX_STOP;
         end
         TX_STOP:   if (tx_tick && (!tx_two || tx_bitn != '0)) tx_nx = TX_IDLE;
         default:   tx_nx = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_div    <= DIV_MIN;
         tx_bitn   <= '0;
         tx_sh     <= '0;
         tx_par    <= 1'b0;
         tx_par_en <= 1'b0;
         tx_two    <= 1'b0;
      end else begin
         tx_state <= tx_nx;
         if (tx_pop) begin
            tx_sh     <= tx_rdata;
            tx_par    <= (^tx_rdata) ^ parity_odd_i;
            tx_par_en <= parity_en_i;
            tx_two    <= two_stop_i;
            tx_div    <= div_eff;
            tx_cnt    <= div_eff - DIV_WIDTH'(1);
            tx_bitn   <= '0;
         end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
               tx_cnt <= tx_div - DIV_WIDTH'(1);
               if (tx_state == TX_DATA) begin
                  tx_sh   <= tx_sh >> 1;
                  tx_bitn <= tx_last ? 4'd0 : tx_bitn + 4'd1;
               end else if (tx_state == TX_STOP) begin
                  tx_bitn <= tx_bitn + 4'd1;
               end
            end else begin
               tx_cnt <= tx_cnt - DIV_WIDTH'(1);
            end
         end
      end
   end

   logic                 rx_sync1, rx_sync2, line;
   rx_state_t            rx_state, rx_nx;
   logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
   logic [3:0]           rx_bitn;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_par_en, rx_odd, rx_perr, rx_tick, rx_last;
   logic                 rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_BITS+1:0] rx_rdata;

   assign line    = loopback_i ? tx_ser : rx_sync2;
   assign rx_tick = (rx_cnt == '0);
   assign rx_last = (rx_bitn == LAST_BIT);
   assign rx_push = (rx_state == RX_STOP) && rx_tick;
   assign rx_pop  = m_axis_tvalid && m_axis_tready;

   axis_uart_fifo_sync #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk_i), .rst(rst_i), .wr(rx_push), .wdata({!line, rx_perr, rx_sh}), .rd(rx_pop),
      .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
   );

   assign m_axis_tvalid = !rx_empty;
   assign m_axis_tdata  = rx_empty ? '0 : rx_rdata[DATA_BITS-1:0];
   assign m_axis_tuser  = rx_empty ? '0 : rx_rdata[DATA_BITS+1:DATA_BITS];

   always_comb begin
      rx_nx = rx_state;
      case (rx_state)
         RX_IDLE:      if (!line) rx_nx = RX_START;
         RX_START:     if (rx_tick) rx_nx = line ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_tick && rx_last) rx_nx = rx_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY:    if (rx_tick) rx_nx = RX_STOP;
         RX_STOP:      if (rx_tick) rx_nx = line ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (line) rx_nx = RX_IDLE;
         default:      rx_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_sync1  <= 1'b1;
         rx_sync2  <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_div    <= DIV_MIN;
         rx_bitn   <= '0;
         rx_sh     <= '0;
         rx_par_en <= 1'b0;
         rx_odd    <= 1'b0;
         rx_perr   <= 1'b0;
      end else begin
         rx_sync1 <= uart_rx_i;
         rx_sync2 <= rx_sync1;
         rx_state <= rx_nx;
         if (rx_state == RX_IDLE) begin
            if (!line) begin
               rx_div    <= div_eff;
               rx_cnt    <= (div_eff >> 1) - DIV_WIDTH'(1);
               rx_par_en <= parity_en_i;
               rx_odd    <= parity_odd_i;
               rx_bitn   <= '0;
               rx_perr   <= 1'b0;
            end
         end else if (rx_state != RX_WAIT_HIGH) begin
            if (rx_tick) begin
               rx_cnt <= rx_div - DIV_WIDTH'(1);
               if (rx_state == RX_DATA) begin
                  rx_sh   <= {line, rx_sh[DATA_BITS-1:1]};
                  rx_bitn <= rx_bitn + 4'd1;
               end else if (rx_state == RX_PARITY) begin
                  rx_perr <= (line != ((^rx_sh) ^ rx_odd));
               end
            end else begin
               rx_cnt <= rx_cnt - DIV_WIDTH'(1);
            end
         end
      end
   end

   // set has priority over clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                  rx_overrun_o <= 1'b0;
      else if (rx_push && rx_full && !rx_pop)     rx_overrun_o <= 1'b1;
      else if (rx_overrun_clr_i)                  rx_overrun_o <= 1'b0;
   end
endmodule

// File: tb/tb_axis_uart_fifo_core.sv
// Directed bench for axis_uart_fifo_core: loopback, parity, framing, overrun,
// glitch rejection, two-stop bursts and mid-frame reset.

module tb_axis_uart_fifo_core;
   localparam int DB = 8;
   localparam int DW = 16;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [DW-1:0] clk_divider_i = 16'd16;
   logic          parity_en_i = 1'b0;
   logic          parity_odd_i = 1'b0;
   logic          two_stop_i = 1'b0;
   logic          loopback_i = 1'b0;
   logic [DB-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DB-1:0] m_axis_tdata;
   logic [1:0]    m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          uart_rx_i = 1'b1;
   logic          uart_tx_o;
   logic          tx_busy_o;
   logic          rx_overrun_o;
   logic          rx_overrun_clr_i = 1'b0;

   int nvec = 0;
   int nerr = 0;

   axis_uart_fifo_core #(.DATA_BITS(DB), .FIFO_DEPTH(16), .DIV_WIDTH(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clk_divider_i(clk_divider_i),
      .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .two_stop_i(two_stop_i),
      .loopback_i(loopback_i), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .uart_rx_i(uart_rx_i),
      .uart_tx_o(uart_tx_o), .tx_busy_o(tx_busy_o), .rx_overrun_o(rx_overrun_o),
      .rx_overrun_clr_i(rx_overrun_clr_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic write_word(input logic [DB-1:0] d);
      @(negedge clk_i);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      @(posedge clk_i);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drive_line(input logic b, input int n);
      uart_rx_i = b;
      repeat (n) @(negedge clk_i);
   endtask

   // external frame at 16 clocks per bit; clr_at>=0 pulses the overrun clear
   // clr_at clocks into the stop bit
   task automatic send_frame(input logic [DB-1:0] d, input logic par_on, input logic par_bit,
                             input logic stop_bit, input int stop_clks, input int clr_at);
      @(negedge clk_i);
      drive_line(1'b0, 16);
      for (int i = 0; i < DB; i++) drive_line(d[i], 16);
      if (par_on) drive_line(par_bit, 16);
      if (clr_at >= 0) begin
         drive_line(stop_bit, clr_at);
         rx_overrun_clr_i = 1'b1;
         @(negedge clk_i);
         rx_overrun_clr_i = 1'b0;
         drive_line(stop_bit, stop_clks - clr_at - 1);
      end else begin
         drive_line(stop_bit, stop_clks);
      end
      drive_line(1'b1, 32);
   endtask

   task automatic pop_word(output logic [DB-1:0] d, output logic [1:0] u, output logic ok);
      for (int i = 0; i < 3000 && !m_axis_tvalid; i++) @(negedge clk_i);
      ok = m_axis_tvalid;
      d  = m_axis_tdata;
      u  = m_axis_tuser;
      m_axis_tready = 1'b1;
      @(negedge clk_i);
      m_axis_tready = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] got;
      #12;
      got = {uart_tx_o, s_axis_tready, m_axis_tvalid, m_axis_tuser, tx_busy_o, rx_overrun_o};
      nvec++;
      if (got !== 7'b1000000) begin
         nerr++;
         $display("FAIL reset_outputs: got %b expected %b", got, 7'b1000000);
      end
      nvec++;
      if (m_axis_tdata !== 8'h00) begin
         nerr++;
         $display("FAIL reset_tdata: got %h expected %h", m_axis_tdata, 8'h00);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      nvec++;
      if (s_axis_tready !== 1'b1) begin
         nerr++;
         $display("FAIL reset_tready_rise: got %b expected 1", s_axis_tready);
      end
   endtask

   task automatic test_loopback();
      int busy_cnt = 0;
      logic pin_hi = 1'b1;
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      loopback_i = 1'b1;
      write_word(8'hA5);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (!uart_tx_o) pin_hi = 1'b0;
         if (tx_busy_o) busy_cnt++;
         else break;
      end
      nvec++;
      if (busy_cnt !== 161) begin
         nerr++;
         $display("FAIL loopback_busy_clocks: got %0d expected %0d", busy_cnt, 161);
      end
      nvec++;
      if (pin_hi !== 1'b1) begin
         nerr++;
         $display("FAIL loopback_pin_idle: got %b expected 1", pin_hi);
      end
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b00, 8'hA5}) begin
         nerr++;
         $display("FAIL loopback_word: got ok=%b user=%b data=%h expected ok=1 user=00 data=a5", ok, u, d);
      end
      loopback_i = 1'b0;
   endtask

   task automatic test_parity();
      int lowc = 0;
      logic [9:0] exp_bits = 10'b10_0000_0011;
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      parity_en_i  = 1'b1;
      parity_odd_i = 1'b0;
      write_word(8'h03);
      for (int c = 0; c < 50 && uart_tx_o; c++) @(negedge clk_i);
      while (uart_tx_o == 1'b0 && lowc < 100) begin
         lowc++;
         @(negedge clk_i);
      end
      nvec++;
      if (lowc !== 16) begin
         nerr++;
         $display("FAIL tx_start_len: got %0d expected 16", lowc);
      end
      repeat (8) @(negedge clk_i);
      for (int i = 0; i < 10; i++) begin
         nvec++;
         if (uart_tx_o !== exp_bits[i]) begin
            nerr++;
            $display("FAIL tx_bit%0d: got %b expected %b", i, uart_tx_o, exp_bits[i]);
         end
         repeat (16) @(negedge clk_i);
      end
      send_frame(8'h03, 1'b1, 1'b1, 1'b1, 16, -1);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b01, 8'h03}) begin
         nerr++;
         $display("FAIL rx_parity_err: got ok=%b user=%b data=%h expected ok=1 user=01 data=03", ok, u, d);
      end
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 16, -1);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b00, 8'h07}) begin
         nerr++;
         $display("FAIL rx_parity_ok: got ok=%b user=%b data=%h expected ok=1 user=00 data=07", ok, u, d);
      end
      parity_en_i = 1'b0;
   endtask

   task automatic test_framing();
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 40, -1);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b10, 8'h55}) begin
         nerr++;
         $display("FAIL rx_frame_err: got ok=%b user=%b data=%h expected ok=1 user=10 data=55", ok, u, d);
      end
      repeat (40) @(negedge clk_i);
      nvec++;
      if (m_axis_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL rx_break_extra_word: got tvalid=%b expected 0", m_axis_tvalid);
      end
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, 16, -1);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b00, 8'h12}) begin
         nerr++;
         $display("FAIL rx_after_break: got ok=%b user=%b data=%h expected ok=1 user=00 data=12", ok, u, d);
      end
   endtask

   task automatic test_overrun();
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      for (int i = 0; i < 16; i++) send_frame(8'(i * 3 + 1), 1'b0, 1'b0, 1'b1, 16, -1);
      nvec++;
      if ({m_axis_tvalid, rx_overrun_o} !== 2'b10) begin
         nerr++;
         $display("FAIL ovr_full16: got tvalid/ovr=%b expected 10", {m_axis_tvalid, rx_overrun_o});
      end
      send_frame(8'hEE, 1'b0, 1'b0, 1'b1, 16, -1);
      nvec++;
      if (rx_overrun_o !== 1'b1) begin
         nerr++;
         $display("FAIL ovr_set: got %b expected 1", rx_overrun_o);
      end
      @(negedge clk_i);
      rx_overrun_clr_i = 1'b1;
      @(negedge clk_i);
      rx_overrun_clr_i = 1'b0;
      nvec++;
      if (rx_overrun_o !== 1'b0) begin
         nerr++;
         $display("FAIL ovr_clear: got %b expected 0", rx_overrun_o);
      end
      send_frame(8'hDD, 1'b0, 1'b0, 1'b1, 16, 10);
      nvec++;
      if (rx_overrun_o !== 1'b1) begin
         nerr++;
         $display("FAIL ovr_set_beats_clr: got %b expected 1", rx_overrun_o);
      end
      for (int i = 0; i < 16; i++) begin
         pop_word(d, u, ok);
         nvec++;
         if ({ok, u, d} !== {1'b1, 2'b00, 8'(i * 3 + 1)}) begin
            nerr++;
            $display("FAIL ovr_word%0d: got ok=%b user=%b data=%h expected ok=1 user=00 data=%h",
                     i, ok, u, d, 8'(i * 3 + 1));
         end
      end
      nvec++;
      if (m_axis_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL ovr_dropped: got tvalid=%b expected 0", m_axis_tvalid);
      end
      rx_overrun_clr_i = 1'b1;
      @(negedge clk_i);
      rx_overrun_clr_i = 1'b0;
   endtask

   task automatic test_glitch();
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      @(negedge clk_i);
      drive_line(1'b0, 4);
      drive_line(1'b1, 40);
      nvec++;
      if (m_axis_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL glitch_word: got tvalid=%b expected 0", m_axis_tvalid);
      end
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, -1);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b00, 8'h3C}) begin
         nerr++;
         $display("FAIL glitch_recover: got ok=%b user=%b data=%h expected ok=1 user=00 data=3c", ok, u, d);
      end
   endtask

   task automatic test_back_to_back();
      two_stop_i = 1'b1;
      @(negedge clk_i);
      s_axis_tdata  = 8'h81;
      s_axis_tvalid = 1'b1;
      @(negedge clk_i);
      s_axis_tdata  = 8'h42;
      @(negedge clk_i);
      s_axis_tdata  = 8'h24;
      @(negedge clk_i);
      s_axis_tvalid = 1'b0;
      for (int c = 3; c < 600; c++) begin
         @(negedge clk_i);
         if (c == 177 || c == 354) begin
            nvec++;
            if (uart_tx_o !== 1'b1) begin
               nerr++;
               $display("FAIL b2b_idle_c%0d: got %b expected 1", c, uart_tx_o);
            end
         end
         if (c == 178 || c == 355) begin
            nvec++;
            if (uart_tx_o !== 1'b0) begin
               nerr++;
               $display("FAIL b2b_start_c%0d: got %b expected 0", c, uart_tx_o);
            end
         end
         if (c == 530 || c == 531) begin
            nvec++;
            if (tx_busy_o !== (c == 530)) begin
               nerr++;
               $display("FAIL b2b_busy_c%0d: got %b expected %b", c, tx_busy_o, (c == 530));
            end
         end
         if (c == 531) break;
      end
      two_stop_i = 1'b0;
      repeat (4) @(negedge clk_i);
   endtask

   task automatic test_reset_mid_frame();
      logic [3:0] got;
      logic [DB-1:0] d;
      logic [1:0] u;
      logic ok;
      write_word(8'h37);
      write_word(8'h01);
      write_word(8'h02);
      write_word(8'h03);
      write_word(8'h04);
      repeat (68) @(negedge clk_i);
      nvec++;
      if (uart_tx_o !== 1'b0) begin
         nerr++;
         $display("FAIL rst_pre_bit3: got %b expected 0", uart_tx_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      got = {uart_tx_o, tx_busy_o, m_axis_tvalid, s_axis_tready};
      nvec++;
      if (got !== 4'b1000) begin
         nerr++;
         $display("FAIL rst_async: got tx/busy/tvalid/tready=%b expected 1000", got);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      nvec++;
      if ({s_axis_tready, tx_busy_o} !== 2'b10) begin
         nerr++;
         $display("FAIL rst_release: got tready/busy=%b expected 10", {s_axis_tready, tx_busy_o});
      end
      loopback_i = 1'b1;
      write_word(8'h5A);
      pop_word(d, u, ok);
      nvec++;
      if ({ok, u, d} !== {1'b1, 2'b00, 8'h5A}) begin
         nerr++;
         $display("FAIL rst_new_word: got ok=%b user=%b data=%h expected ok=1 user=00 data=5a", ok, u, d);
      end
      nvec++;
      if (m_axis_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL rst_queue_flushed: got tvalid=%b expected 0", m_axis_tvalid);
      end
      loopback_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_parity();
      test_framing();
      test_overrun();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/axis_uart_fifo_core.md
Name: axis_uart_fifo_core

Overview:
Parametrised full-duplex UART with AXI-Stream ports, the successor to the fixed 8-bit loop-through UART top. Adds:
- configurable data width
- runtime divider, parity and stop-bit mode
- TX and RX FIFOs
- internal loopback
- per-word error flags in tuser, plus a sticky overrun flag

It sits between a CSR/DMA AXIS fabric and the board UART pins.

Parameters:
DATA_BITS, 8, character width; legal 5..9.
FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, at least 2.
DIV_WIDTH, 16, width of the clk_divider_i input.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
clk_divider_i  in  DIV_WIDTH  clocks per bit; values below 4 are treated as 4
parity_en_i  in  1  1 = parity bit present
parity_odd_i  in  1  1 = odd parity, 0 = even parity
two_stop_i  in  1  1 = two stop bits transmitted
loopback_i  in  1  1 = internal TX-to-RX loop, pin held idle
s_axis_tdata  in  DATA_BITS  TX character
s_axis_tvalid  in  1  TX valid
s_axis_tready  out  1  TX FIFO not full
m_axis_tdata  out  DATA_BITS  RX character
m_axis_tuser  out  2  [0] parity error, [1] framing error
m_axis_tvalid  out  1  RX FIFO not empty
m_axis_tready  in  1  RX ready
uart_rx_i  in  1  serial input (asynchronous)
uart_tx_o  out  1  serial output
tx_busy_o  out  1  TX FIFO non-empty or TX FSM not IDLE
rx_overrun_o  out  1  sticky flag: RX word dropped
rx_overrun_clr_i  in  1  clears rx_overrun_o

Behaviour:
- Reset (asynchronous, while rst_i=1):
  - uart_tx_o=1; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tuser=0.
  - tx_busy_o=0; rx_overrun_o=0.
  - Both FIFOs empty; both FSMs IDLE; RX synchroniser flops =1.
  - s_axis_tready rises in the first cycle after release.
- Reset mid-frame aborts the frame: the pin returns to 1 immediately and all queued data is discarded.
- Configuration inputs (divider, parity, stop bits) are latched at each frame start (TX pop, RX start detect). Changes mid-frame never affect the frame in flight.
- Frame format:
  - start bit 0, then DATA_BITS data bits LSB first, then the optional parity bit, then 1 stop bit (2 if two_stop_i).
  - Every bit lasts exactly the latched divider value in clocks.
  - Parity bit = XOR of data bits, inverted when parity_odd_i=1.
- TX FIFO:
  - A write occurs on s_axis_tvalid & s_axis_tready; s_axis_tready = !full, gated low during reset.
  - A simultaneous write and pop when full is accepted.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if !parity_en) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty: pop, then uart_tx_o falls on the next cycle.
  - Back-to-back frames have exactly one idle-high clock between the end of the last stop bit and the next start bit.
- RX synchroniser: two flops on uart_rx_i.
  - The line seen by the RX FSM is the synchronised pin, or the internal TX serial bit when loopback_i=1.
  - uart_tx_o is forced to 1 while loopback_i=1.
  - Toggling loopback_i mid-frame may corrupt that frame, but both FSMs must return to IDLE.
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> (WAIT_HIGH) -> IDLE.
  - IDLE: the line at 0 starts START.
  - START: after floor(div/2) clocks, re-sample. If the line is 1, it is a false start: return to IDLE and push nothing.
  - DATA and PARITY: sample every div clocks. parity_err = (received parity != computed parity); it is 0 when parity is disabled.
  - STOP: sample only the first stop bit; frame_err = (sample == 0). Push {frame_err, parity_err, data} to the RX FIFO.
  - If frame_err, go to WAIT_HIGH until the line is 1 (break handling); otherwise go to IDLE.
- RX FIFO:
  - First-word fall-through; the word appears on m_axis one cycle after the stop-bit sample.
  - m_axis_tdata and m_axis_tuser stay stable while tvalid=1 and tready=0.
  - Push while full with no pop in the same cycle: the word is dropped and rx_overrun_o is set. Push while full with a pop in the same cycle: accepted.
  - rx_overrun_o stays 1 until rx_overrun_clr_i=1. If set and clear occur in the same cycle, set wins.
- RX runs independently of TX; full duplex is supported in non-loopback mode.

Test Plan:
- Loopback=1, div=16, 8N1, write 0xA5 -> m_axis 0xA5, tuser=0; uart_tx_o stays 1 throughout; internal frame lasts 160 clocks.
- Non-loopback, parity_en=1, even parity, write 0x03 -> pin shows start, 1,1,0,0,0,0,0,0, parity 0, stop 1, each 16 clocks. Then inject an external frame 0x03 with parity bit 1 -> word 0x03 with tuser=01.
- Inject external 0x55 with stop bit 0, line held low 40 clocks -> tuser=10; no second word is produced; the next valid frame 0x12 is received correctly.
- m_axis_tready=0; inject 17 frames -> first 16 retained in order, rx_overrun_o=1, 17th dropped. Pulse clr -> 0. Set and clr in the same cycle -> stays 1.
- Inject a 4-clock low glitch with div=16 -> no word, FSM back in IDLE. Then run two_stop=1 with a burst of 3 TX words -> frames separated by 2 stop bits plus 1 idle clock; tx_busy_o falls after the third stop bit.
- Assert rst_i during TX data bit 3 with 5 words queued -> uart_tx_o=1 asynchronously, tx_busy_o=0, m_axis_tvalid=0. After release, s_axis_tready=1 and a new word transmits cleanly.
